alu_exec_sequencer: RTL
=======================

// Module: alu_exec_sequencer
// PURPOSE
//  Multi-cycle execute controller for the 16-bit ALU. Accepts one 16-bit instruction over a
//  valid/ready handshake and reads Rdest/Rsrc from the register file. Drives the combinational
//  ALU (A, B, Opcode), captures C and Flags, writes C back to Rdest and maintains the 5-bit PSR (ZCFNL).
//  Sits between instruction decode/fetch and the ALU + register file.
// PARAMETERS
//  DATA_W   16  datapath width; must match the ALU
//  REG_AW   4   register-file address width (16 registers)
//  FLAG_W   5   PSR width; bit indices Z=4 C=3 F=2 N=1 L=0
// PORTS
//  clk          in   1        system clock; all state on rising edge
//  reset        in   1        synchronous, active-high; one clock, one reset
//  instr_valid  in   1        instr is valid this cycle
//  instr_ready  out  1        sequencer can accept; high only in IDLE
//  instr        in   16       [15:12] op, [11:8] Rdest, [7:4] ext/immHi, [3:0] Rsrc/immLo
//  rf_ra_addr   out  REG_AW   read port A address (= Rdest)
//  rf_rb_addr   out  REG_AW   read port B address (= Rsrc)
//  rf_ra_data   in   DATA_W   read data A; combinational read
//  rf_rb_data   in   DATA_W   read data B; combinational read
//  alu_a        out  DATA_W   ALU operand A (registered)
//  alu_b        out  DATA_W   ALU operand B (registered)
//  alu_op       out  8        ALU opcode (registered)
//  alu_c        in   DATA_W   ALU result
//  alu_flags    in   FLAG_W   ALU flags
//  rf_we        out  1        register-file write enable; one-cycle pulse
//  rf_wa        out  REG_AW   write address
//  rf_wd        out  DATA_W   write data
//  psr          out  FLAG_W   processor status register
//  done         out  1        one-cycle pulse; instruction retired
// BEHAVIOUR
//  Reset: state=IDLE. instr_ready=1 in IDLE. rf_we=0, done=0, psr=0, alu_a/alu_b=0.
//   alu_op=8'h00 (WAIT). Instruction latch=0.
//  FSM: IDLE -> READ -> EXEC -> WB -> IDLE. There are no other transitions except reset.
//  IDLE: instr_valid & instr_ready latches instr; go to READ. If valid is low, stay in IDLE.
//  READ: rf_ra_addr=instr[11:8], rf_rb_addr=instr[3:0].
//   Register alu_a=rf_ra_data. Register alu_op={instr[15:12], instr[7:4]}.
//   alu_b: if op==4'b0000 (register form), alu_b=rf_rb_data.
//   Otherwise (immediate form), alu_b=ext(instr[7:0]).
//  ext(): sign-extend for op in {0101 ADDI, 0111 ADDCI, 1001 SUBI, 1011 CMPI}; zero-extend for all others.
//  EXEC: the ALU settles within the cycle. Capture alu_c into rf_wd and rf_wa=instr[11:8].
//   psr<=alu_flags unless alu_op==8'h00.
//  WB: rf_we=1 for exactly this cycle, unless the instruction is no-writeback.
//   No-writeback: CMP (8'h0B), CMPI (op 1011), WAIT/NOP (8'h00).
//   done=1 this cycle; next state IDLE.
//  Latency: accept at edge N, done/rf_we at cycle N+3. Throughput: 1 instruction per 4 cycles.
//  Handshake: instr_ready depends on state only. instr is ignored outside IDLE.
//   instr_valid dropping mid-operation has no effect.
//  Rdest==Rsrc: both read ports use the same address; this is legal. The write lands in WB, after the read.
//  Back-to-back dependent instructions: there is no hazard. The WB write commits before the next READ.
//  Flags: alu_flags is stored unmodified. psr is held between instructions and across WAIT.
//  Reset mid-operation (any state): next cycle is IDLE. rf_we=0, done=0 and psr=0 that cycle.
//   The in-flight write is dropped.
//  Unknown opcodes: the ALU default (C=0, Flags=0) is written back and stored like any ALU op.
// STRUCTURE
//  Shared include alu_defs.vh holds:
//   - ALU opcode constants (ADD 8'h05, ADDU 8'h06, ADDC 8'h07, SUB 8'h09, CMP 8'h0B,
//     AND 8'h01, OR 8'h02, XOR 8'h03, WAIT 8'h00)
//   - op-nibble constants for the immediate forms
//   - flag bit indices Z/C/F/N/L
//   - FSM state encodings (2-bit)
//  One sub-module, alu_operand_sel: combinational immediate extend + B-operand mux.
//   Inputs: instr and rf_rb_data. Output: operand B.
//  The ALU and register file are instantiated by the parent, not here.
// TESTING
//  1. Preload R1=0x0003, R2=0x0004. ADD R1,R2 (0x0152).
//     -> rf_we at N+3, rf_wa=1, rf_wd=0x0007, psr=0, done pulse.
//  2. R3=0x0005. ADDI R3,#-5 (0x53FB).
//     -> alu_b=0xFFFB, rf_wd=0x0000, psr[4](Z)=1.
//  3. R4=0x0002, R5=0x0009. CMP R4,R5 (0x04B5).
//     -> rf_we stays 0 all 4 cycles, psr[1:0]=2'b11, done pulse. R4 unchanged.
//  4. Hold instr_valid=1 with ADD then SUB.
//     -> instr_ready high only every 4th cycle; the second instruction is accepted exactly 4 cycles after the first.
//  5. Assert reset during EXEC of ADD R1,R2.
//     -> rf_we never pulses, psr=0. instr_ready=1 the cycle after reset.
//  6. ADD R6,R6 with R6=0x4000.
//     -> rf_wd=0x8000, psr[2](F)=1. The next ADD R6,R6 reads 0x8000: no stale data.

Source files
------------

// File: rtl/alu_exec_sequencer_pkg.sv
// Shared definitions for the ALU execute sequencer: ALU opcodes, immediate-form
// op nibbles, PSR bit positions, FSM states and small decode helpers.
package alu_exec_sequencer_pkg;

    localparam int ALU_DATA_W = 16;
    localparam int ALU_REG_AW = 4;
    localparam int ALU_FLAG_W = 5;

    localparam logic [7:0] OP_WAIT = 8'h00;
    localparam logic [7:0] OP_AND  = 8'h01;
    localparam logic [7:0] OP_OR   = 8'h02;
    localparam logic [7:0] OP_XOR  = 8'h03;
    localparam logic [7:0] OP_ADD  = 8'h05;
    localparam logic [7:0] OP_ADDU = 8'h06;
    localparam logic [7:0] OP_ADDC = 8'h07;
    localparam logic [7:0] OP_SUB  = 8'h09;
    localparam logic [7:0] OP_CMP  = 8'h0B;

    localparam logic [3:0] NIB_REG   = 4'h0;
    localparam logic [3:0] NIB_ADDI  = 4'h5;
    localparam logic [3:0] NIB_ADDCI = 4'h7;
    localparam logic [3:0] NIB_SUBI  = 4'h9;
    localparam logic [3:0] NIB_CMPI  = 4'hB;

    localparam int FLAG_Z = 4;
    localparam int FLAG_C = 3;
    localparam int FLAG_F = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_L = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } seq_state_e;

    // Arithmetic immediates take a signed 8-bit value; logical ones are unsigned.
    function automatic logic imm_is_signed(input logic [3:0] op);
        logic res;
        case (op)
            NIB_ADDI, NIB_ADDCI, NIB_SUBI, NIB_CMPI: res = 1'b1;
            default:                                 res = 1'b0;
        endcase
        return res;
    endfunction

    function automatic logic op_writes_back(input logic [7:0] alu_op);
        logic res;
        if ((alu_op == OP_CMP) || (alu_op[7:4] == NIB_CMPI) || (alu_op == OP_WAIT)) begin
            res = 1'b0;
        end else begin
            res = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/alu_exec_sequencer_operand_sel.sv
// B-operand selection: register read data for the register form, otherwise the
// 8-bit immediate sign- or zero-extended according to the op nibble.
module alu_operand_sel
    import alu_exec_sequencer_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W
) (
    input  logic [15:0]       instr,
    input  logic [DATA_W-1:0] rf_rb_data,
    output logic [DATA_W-1:0] operand_b
);

    logic [3:0] op_s;
    logic [7:0] imm_s;
    logic       unused_rdest_s;

    assign op_s           = instr[15:12];
    assign imm_s          = instr[7:0];
    assign unused_rdest_s = ^instr[11:8];

    // Operand B mux with immediate extension.
    always_comb begin
        operand_b = {DATA_W{1'b0}};
        if (op_s == NIB_REG) begin
            operand_b = rf_rb_data;
        end else if (imm_is_signed(op_s)) begin
            operand_b = {{(DATA_W-8){imm_s[7]}}, imm_s};
        end else begin
            operand_b = {{(DATA_W-8){1'b0}}, imm_s};
        end
    end

endmodule

// File: rtl/alu_exec_sequencer.sv
// Four-state execute controller: accept, read operands, capture ALU result and
// flags, then write back and retire. One instruction every four cycles.
module alu_exec_sequencer
    import alu_exec_sequencer_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int REG_AW = ALU_REG_AW,
    parameter int FLAG_W = ALU_FLAG_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       instr,
    output logic [REG_AW-1:0] rf_ra_addr,
    output logic [REG_AW-1:0] rf_rb_addr,
    input  logic [DATA_W-1:0] rf_ra_data,
    input  logic [DATA_W-1:0] rf_rb_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [7:0]        alu_op,
    input  logic [DATA_W-1:0] alu_c,
    input  logic [FLAG_W-1:0] alu_flags,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_wa,
    output logic [DATA_W-1:0] rf_wd,
    output logic [FLAG_W-1:0] psr,
    output logic              done
);

    seq_state_e        state_q, state_d;
    logic [15:0]       instr_q, instr_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [7:0]        alu_op_q, alu_op_d;
    logic [REG_AW-1:0] rf_wa_q, rf_wa_d;
    logic [DATA_W-1:0] rf_wd_q, rf_wd_d;
    logic [FLAG_W-1:0] psr_q, psr_d;
    logic              rf_we_q, rf_we_d;
    logic              done_q, done_d;
    logic              instr_ready_q, instr_ready_d;
    logic [DATA_W-1:0] operand_b_s;

    alu_operand_sel #(
        .DATA_W (DATA_W)
    ) u_operand_sel (
        .instr      (instr_q),
        .rf_rb_data (rf_rb_data),
        .operand_b  (operand_b_s)
    );

    // Next-state and registered-output computation; everything holds by default.
    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_op_d = alu_op_q;
        rf_wa_d  = rf_wa_q;
        rf_wd_d  = rf_wd_q;
        psr_d    = psr_q;
        rf_we_d  = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (instr_valid && instr_ready_q) begin
                    instr_d = instr;
                    state_d = ST_READ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                alu_a_d  = rf_ra_data;
                alu_b_d  = operand_b_s;
                alu_op_d = {instr_q[15:12], instr_q[7:4]};
                state_d  = ST_EXEC;
            end
            ST_EXEC: begin
                // rf_we/done are launched here so they are high for the whole WB cycle.
                rf_wd_d = alu_c;
                rf_wa_d = instr_q[11:8];
                if (alu_op_q != OP_WAIT) begin
                    psr_d = alu_flags;
                end else begin
                    psr_d = psr_q;
                end
                rf_we_d = op_writes_back(alu_op_q);
                done_d  = 1'b1;
                state_d = ST_WB;
            end
            ST_WB: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        instr_ready_d = (state_d == ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            instr_q       <= 16'h0000;
            alu_a_q       <= {DATA_W{1'b0}};
            alu_b_q       <= {DATA_W{1'b0}};
            alu_op_q      <= OP_WAIT;
            rf_wa_q       <= {REG_AW{1'b0}};
            rf_wd_q       <= {DATA_W{1'b0}};
            psr_q         <= {FLAG_W{1'b0}};
            rf_we_q       <= 1'b0;
            done_q        <= 1'b0;
            instr_ready_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            instr_q       <= instr_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_op_q      <= alu_op_d;
            rf_wa_q       <= rf_wa_d;
            rf_wd_q       <= rf_wd_d;
            psr_q         <= psr_d;
            rf_we_q       <= rf_we_d;
            done_q        <= done_d;
            instr_ready_q <= instr_ready_d;
        end
    end

    assign instr_ready = instr_ready_q;
    assign rf_ra_addr  = instr_q[11:8];
    assign rf_rb_addr  = instr_q[3:0];
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_op      = alu_op_q;
    assign rf_we       = rf_we_q;
    assign rf_wa       = rf_wa_q;
    assign rf_wd       = rf_wd_q;
    assign psr         = psr_q;
    assign done        = done_q;

endmodule
